bp_me_cce_mem_arb: RTL and testbench

- Shares one CCE-to-cache memory-command port among num_req_p requesters (e.g. CCE and I/O/DMA masters) in front of the L2 converter.
- Round-robin arbitration of commands. Responses are routed back using an in-order requester-ID FIFO; the downstream converter returns responses in command order.
- A drain/quiesce FSM lets software or the boot sequencer stop new issue and wait for all outstanding responses.

---
 rtl/bp_me_pkg.sv | 8 +
 rtl/bp_me_cce_mem_arb_fifo.sv | 47 ++++
 rtl/bp_me_cce_mem_arb.sv | 98 +++++++++
 tb/tb_bp_me_cce_mem_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the CCE memory-port arbiter: message width and arbiter FSM states.
package bp_me_pkg;

   localparam int cce_mem_msg_width_lp = 64;

   typedef enum logic [1:0] {e_reset, e_run, e_drain} bp_me_arb_state_e;

endpackage

// File: rtl/bp_me_cce_mem_arb_fifo.sv
// Small in-order FIFO holding requester IDs of outstanding commands; 1-cycle write-to-read.
// Backpressure: ready deasserts when full; head is valid combinationally while non-empty.
module bp_me_cce_mem_arb_fifo #(
   parameter int width_p = 1,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic [width_p-1:0] data_o,
   output logic               v_o,
   input  logic               yumi_i
);
   localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_width_lp = $clog2(els_p + 1);

   logic [width_p-1:0]      mem [els_p];
   logic [ptr_width_lp-1:0] wptr, rptr;
   logic [cnt_width_lp-1:0] cnt;
   logic                    push, pop;

   assign ready_o = (cnt != cnt_width_lp'(els_p));
   assign v_o     = (cnt != '0);
   assign data_o  = mem[rptr];
   assign push    = v_i & ready_o;
   assign pop     = yumi_i & v_o;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= (wptr == ptr_width_lp'(els_p - 1)) ? '0 : wptr + 1'b1;
         if (pop)  rptr <= (rptr == ptr_width_lp'(els_p - 1)) ? '0 : rptr + 1'b1;
         cnt <= cnt + cnt_width_lp'(push) - cnt_width_lp'(pop);
      end
   end

   // Storage needs no reset; only entries below cnt are ever observed.
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= data_i;
   end

endmodule

// File: rtl/bp_me_cce_mem_arb.sv
// Round-robin sharing of one memory-command port among num_req_p requesters, in-order response routing.
// Latency: command and response paths are combinational; a stalled grant is locked until its handshake.
module bp_me_cce_mem_arb
   import bp_me_pkg::*;
#(
   parameter int num_req_p     = 2,
   parameter int outstanding_p = 4
) (
   input  logic                                      clk_i,
   input  logic                                      reset_ni,
   input  logic [num_req_p*cce_mem_msg_width_lp-1:0] req_mem_cmd_i,
   input  logic [num_req_p-1:0]                      req_mem_cmd_v_i,
   output logic [num_req_p-1:0]                      req_mem_cmd_ready_o,
   output logic [cce_mem_msg_width_lp-1:0]           req_mem_resp_o,
   output logic [num_req_p-1:0]                      req_mem_resp_v_o,
   input  logic [num_req_p-1:0]                      req_mem_resp_yumi_i,
   output logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o,
   output logic                                      mem_cmd_v_o,
   input  logic                                      mem_cmd_ready_i,
   input  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i,
   input  logic                                      mem_resp_v_i,
   output logic                                      mem_resp_yumi_o,
   input  logic                                      drain_i,
   output logic                                      idle_o
);
   localparam int lg_num_req_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int count_width_lp = $clog2(outstanding_p + 1);

   bp_me_arb_state_e          state_r;
   logic [lg_num_req_lp-1:0]  rr_ptr, lock_id, rr_id, sel, head;
   logic                      lock, eligible, issue, fifo_ready, fifo_v, route;
   logic [count_width_lp-1:0] count;

   // First valid requester at or after rr_ptr; lowest offset wins.
   always_comb begin
      rr_id = rr_ptr;
      for (int i = num_req_p - 1; i >= 0; i--) begin
         if (req_mem_cmd_v_i[(int'(rr_ptr) + i) % num_req_p])
            rr_id = lg_num_req_lp'((int'(rr_ptr) + i) % num_req_p);
      end
   end

   assign sel      = lock ? lock_id : rr_id;
   assign eligible = ((state_r == e_run) || lock) && (count < count_width_lp'(outstanding_p)) && fifo_ready;
   assign mem_cmd_v_o = eligible && req_mem_cmd_v_i[sel];
   assign mem_cmd_o   = req_mem_cmd_i[int'(sel)*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
   assign issue       = mem_cmd_v_o & mem_cmd_ready_i;
   assign req_mem_cmd_ready_o = issue ? (num_req_p'(1) << sel) : '0;

   // Converter answers in command order, so the FIFO head owns the current response.
   assign route            = mem_resp_v_i & fifo_v;
   assign req_mem_resp_o   = mem_resp_i;
   assign req_mem_resp_v_o = route ? (num_req_p'(1) << head) : '0;
   assign mem_resp_yumi_o  = route & req_mem_resp_yumi_i[head];
   assign idle_o           = (state_r == e_drain) && (count == '0) && !lock;

   bp_me_cce_mem_arb_fifo #(
      .width_p(lg_num_req_lp),
      .els_p  (outstanding_p)
   ) id_fifo (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .data_i  (sel),
      .v_i     (issue),
      .ready_o (fifo_ready),
      .data_o  (head),
      .v_o     (fifo_v),
      .yumi_i  (mem_resp_yumi_o)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r <= e_reset;
         rr_ptr  <= '0;
         lock    <= 1'b0;
         lock_id <= '0;
         count   <= '0;
      end else begin
         case (state_r)
            e_reset: state_r <= e_run;
            e_run:   if (drain_i) state_r <= e_drain;
            e_drain: if (!drain_i) state_r <= e_run;
            default: state_r <= e_reset;
         endcase
         if (issue) begin
            rr_ptr <= (sel == lg_num_req_lp'(num_req_p - 1)) ? '0 : sel + 1'b1;
            lock   <= 1'b0;
         end else if (mem_cmd_v_o) begin
            lock    <= 1'b1;
            lock_id <= sel;
         end
         count <= count + count_width_lp'(issue) - count_width_lp'(mem_resp_yumi_o);
      end
   end

   resp_has_owner: assert property (@(posedge clk_i) disable iff (!reset_ni) mem_resp_v_i |-> fifo_v);

endmodule

// File: tb/tb_bp_me_cce_mem_arb.sv
// Randomized bench for bp_me_cce_mem_arb against a queue-based model of arbitration and response order.
module tb_bp_me_cce_mem_arb;
   import bp_me_pkg::*;

   localparam int N   = 2;
   localparam int OUT = 4;
   localparam int W   = cce_mem_msg_width_lp;

   logic           clk_i = 1'b0;
   logic           reset_ni;
   logic [N*W-1:0] req_mem_cmd_i;
   logic [N-1:0]   req_mem_cmd_v_i, req_mem_cmd_ready_o, req_mem_resp_v_o, req_mem_resp_yumi_i;
   logic [W-1:0]   req_mem_resp_o, mem_cmd_o, mem_resp_i;
   logic           mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o, drain_i, idle_o;

   always #5 clk_i = ~clk_i;

   bp_me_cce_mem_arb #(.num_req_p(N), .outstanding_p(OUT)) dut (
      .clk_i              (clk_i),
      .reset_ni           (reset_ni),
      .req_mem_cmd_i      (req_mem_cmd_i),
      .req_mem_cmd_v_i    (req_mem_cmd_v_i),
      .req_mem_cmd_ready_o(req_mem_cmd_ready_o),
      .req_mem_resp_o     (req_mem_resp_o),
      .req_mem_resp_v_o   (req_mem_resp_v_o),
      .req_mem_resp_yumi_i(req_mem_resp_yumi_i),
      .mem_cmd_o          (mem_cmd_o),
      .mem_cmd_v_o        (mem_cmd_v_o),
      .mem_cmd_ready_i    (mem_cmd_ready_i),
      .mem_resp_i         (mem_resp_i),
      .mem_resp_v_i       (mem_resp_v_i),
      .mem_resp_yumi_o    (mem_resp_yumi_o),
      .drain_i            (drain_i),
      .idle_o             (idle_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: phase 0=post-reset, 1=running, 2=draining; q lists owners of outstanding commands.
   int         m_phase, m_next, m_lock, m_lock_id;
   int         q[$];
   bit         pend[N];
   logic [W-1:0] pdat[N];
   int         p_new, p_ready, p_resp, p_yumi;
   bit         drain;
   int         gcnt[N];

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && ($urandom_range(99) < p_new)) begin
            pend[i] = 1'b1;
            pdat[i] = {$urandom, $urandom};
         end
         req_mem_cmd_v_i[i]       = pend[i];
         req_mem_cmd_i[i*W +: W]  = pdat[i];
         req_mem_resp_yumi_i[i]   = ($urandom_range(99) < p_yumi);
      end
      mem_cmd_ready_i = ($urandom_range(99) < p_ready);
      mem_resp_v_i    = (q.size() > 0) && ($urandom_range(99) < p_resp);
      mem_resp_i      = {$urandom, $urandom};
      drain_i         = drain;
   endtask

   task automatic check_step();
      int sel, head;
      bit any, elig, exp_v, hs, route, yum;
      sel = 0;
      any = 1'b0;
      if (m_lock != 0) begin
         sel = m_lock_id;
         any = pend[sel];
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_next + k) % N;
            if (pend[c] && !any) begin
               sel = c;
               any = 1'b1;
            end
         end
      end
      elig  = ((m_phase == 1) || (m_lock != 0)) && (q.size() < OUT);
      exp_v = elig && any;
      hs    = exp_v && mem_cmd_ready_i;
      check("cmd_v", {63'd0, mem_cmd_v_o}, {63'd0, exp_v});
      if (exp_v) check("cmd_dat", mem_cmd_o, pdat[sel]);
      check("cmd_ready", {62'd0, req_mem_cmd_ready_o}, hs ? (64'd1 << sel) : 64'd0);
      route = mem_resp_v_i && (q.size() > 0);
      head  = route ? q[0] : 0;
      check("resp_v", {62'd0, req_mem_resp_v_o}, route ? (64'd1 << head) : 64'd0);
      if (route) check("resp_dat", req_mem_resp_o, mem_resp_i);
      yum = route && req_mem_resp_yumi_i[head];
      check("resp_yumi", {63'd0, mem_resp_yumi_o}, {63'd0, yum});
      check("idle", {63'd0, idle_o}, {63'd0, (m_phase == 2) && (q.size() == 0) && (m_lock == 0)});
      if (hs) gcnt[sel]++;
      if (yum) void'(q.pop_front());
      if (hs) begin
         q.push_back(sel);
         m_next  = (sel + 1) % N;
         m_lock  = 0;
         pend[sel] = 1'b0;
      end else if (exp_v) begin
         m_lock    = 1;
         m_lock_id = sel;
      end
      if (m_phase == 0)                m_phase = 1;
      else if (m_phase == 1 && drain)  m_phase = 2;
      else if (m_phase == 2 && !drain) m_phase = 1;
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
         drive();
         #3;
         check_step();
      end
   endtask

   // Asserts reset just after an edge, checks outputs settle at once, then releases.
   task automatic do_reset();
      @(posedge clk_i);
      #1;
      reset_ni = 1'b0;
      #1;
      check("rst_cmd_v", {63'd0, mem_cmd_v_o}, 64'd0);
      check("rst_cmd_ready", {62'd0, req_mem_cmd_ready_o}, 64'd0);
      check("rst_resp_v", {62'd0, req_mem_resp_v_o}, 64'd0);
      check("rst_resp_yumi", {63'd0, mem_resp_yumi_o}, 64'd0);
      check("rst_idle", {63'd0, idle_o}, 64'd0);
      repeat (2) @(posedge clk_i);
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      q.delete();
      m_phase = 0; m_next = 0; m_lock = 0; m_lock_id = 0;
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      drive();
      #3;
      check_step();
   endtask

   initial begin
      reset_ni = 1'b1;
      req_mem_cmd_i = '0; req_mem_cmd_v_i = '0; req_mem_resp_yumi_i = '0;
      mem_cmd_ready_i = 1'b0; mem_resp_i = '0; mem_resp_v_i = 1'b0; drain_i = 1'b0;
      p_new = 0; p_ready = 0; p_resp = 0; p_yumi = 0; drain = 1'b0;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pdat[i] = '0; gcnt[i] = 0; end
      do_reset();

      // single requester read, then its response
      pend[0] = 1'b1; pdat[0] = 64'h0000_0003_8000_0000; p_ready = 100;
      cycle(1);
      p_resp = 100; p_yumi = 100;
      cycle(2);

      // both requesters continuously valid: strict alternation
      p_new = 100;
      cycle(1);
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      cycle(16);
      check("fair_req0", 64'(gcnt[0]), 64'd8);
      check("fair_req1", 64'(gcnt[1]), 64'd8);

      // stall while req0 is granted; req1 appears meanwhile
      p_new = 0;
      cycle(4);
      pend[0] = 1'b1; pdat[0] = {$urandom, $urandom}; p_ready = 0;
      cycle(1);
      pend[1] = 1'b1; pdat[1] = {$urandom, $urandom};
      cycle(2);
      p_ready = 100;
      cycle(3);

      // fill to the outstanding limit, then release one response at a time
      p_new = 100; p_resp = 0;
      cycle(8);
      p_resp = 100;
      cycle(3);

      // response held off by requester
      p_yumi = 0;
      cycle(2);
      p_yumi = 100; p_new = 0;
      cycle(6);

      // drain with two outstanding
      p_resp = 0; pend[0] = 1'b1; pend[1] = 1'b1;
      cycle(2);
      drain = 1'b1; p_new = 100;
      cycle(2);
      p_resp = 100;
      cycle(6);
      drain = 1'b0;
      cycle(4);

      // randomized traffic
      for (int b = 0; b < 40; b++) begin
         p_new   = $urandom_range(100, 20);
         p_ready = $urandom_range(100, 10);
         p_resp  = $urandom_range(100, 10);
         p_yumi  = $urandom_range(100, 10);
         drain   = ($urandom_range(9) == 0);
         cycle(50);
      end
      drain = 1'b0;

      // reset in the middle of traffic
      p_new = 100; p_ready = 50; p_resp = 50; p_yumi = 50;
      cycle(5);
      do_reset();
      cycle(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
